collision_scanner: RTL and testbench
====================================

Name: collision_scanner

Overview:
- Parametrised successor to the per-frame map/character collision check.
- Handles one player plus NUM_ENEMIES enemies, time-multiplexed over a single external level-map ROM port (1-cycle read latency) instead of one ROM per corner.
- Started once per frame by control; reports registered map-collision flags per entity and player-enemy overlap flags per enemy, with a start/busy/done handshake.

Parameters:
- NUM_ENEMIES, 2, number of enemies scanned (1..8)
- SPRITE_SIZE, 16, sprite edge in pixels; corners at offset 0 and SPRITE_SIZE-1
- MOVE_PX, 1, probe shift in pixels along the requested direction
- SCREEN_W, 320, map width in pixels; also the address row stride
- SCREEN_H, 240, map height in pixels

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request a scan; sampled only in IDLE
- char_x  in  9  player top-left x
- char_y  in  8  player top-left y
- direction_char  in  3  player move code
- enemy_x  in  9*NUM_ENEMIES  packed enemy x; enemy i at [9i+8:9i]
- enemy_y  in  8*NUM_ENEMIES  packed enemy y
- direction_enemy  in  3*NUM_ENEMIES  packed enemy move codes
- map_addr  out  17  level-map read address = y*SCREEN_W + x
- map_q  in  1  map data for the address of the previous cycle; 1 = walkable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse when results update
- c_map_collision  out  1  player probe box hits wall or screen edge
- e_map_collision  out  NUM_ENEMIES  per-enemy probe box hits wall or edge
- c_e_collision  out  NUM_ENEMIES  player overlaps enemy i

Behaviour:
- Direction codes: 000 NO_ACTION, 001 ATTACK, 010 UP, 011 DOWN, 100 LEFT, 101 RIGHT. Codes 110 and 111 are treated as NO_ACTION.
- Reset (reset==0 at an edge): state IDLE, busy=0, done=0, map_addr=0, all collision outputs 0.
  - Reset mid-scan aborts the scan with no done pulse.
- IDLE: on start=1, latch all position and direction inputs, clear internal accumulators, go to PROBE. Input changes during a scan are ignored.
- Probe box: shift the latched top-left by MOVE_PX according to direction.
  - UP: y-MOVE_PX. DOWN: y+MOVE_PX. LEFT: x-MOVE_PX. RIGHT: x+MOVE_PX.
  - NO_ACTION and ATTACK: no shift.
  - All four corners use the shifted origin: TL, TR(+S-1,0), BL(0,+S-1), BR(+S-1,+S-1).
- Bounds: compute with 1 extra bit. A corner with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H is blocked. For such a corner, map_addr=0 and map_q is ignored.
- PROBE order and timing:
  - Entity 0 is the player, then enemies 0..N-1. Corner order per entity is TL, TR, BL, BR.
  - One address per cycle, 4*(N+1) cycles in total.
- Result capture: map_q is evaluated one cycle after its address. A corner with map_q=0 sets that entity's flag. Flags are OR-accumulated across the entity's four corners.
- WAIT: one cycle to capture the last map_q. Then DONE.
- DONE (one cycle):
  - Outputs load atomically from the accumulators; done=1, busy=0.
  - Next state is IDLE.
  - Outputs hold until the next DONE or reset.
- Latency: start sampled at edge k gives done visible in cycle k+4(N+1)+2. For N=2 that is 14 cycles.
- Overlap: for each enemy, c_e_collision[i] = (|char_x-ex_i| < SPRITE_SIZE) && (|char_y-ey_i| < SPRITE_SIZE).
  - Uses latched, unshifted positions.
  - Computed during PROBE and loaded at DONE.
- start held high: a new scan begins in the cycle after DONE (back-to-back allowed). start during busy has no effect.

Optional Feature:
- Macro: COLLISION_ENEMY_PAIR_EN.
- Defined: adds output port e_e_collision [NUM_ENEMIES-1:0].
  - Bit i is set if enemy i overlaps any other enemy j≠i, using the same overlap rule.
  - Evaluated over the enemy pairs, one comparator per cycle during PROBE, so total latency is unchanged.
  - Loaded at DONE; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench ROM with 1-cycle latency, walls at x>=200. Player (183,100) RIGHT → c_map_collision=0 (right corners at x=199). Player (184,100) RIGHT → c_map_collision=1.
- Player (0,50) LEFT → c_map_collision=1 via the x<0 bound. Player (0,50) NO_ACTION on an all-walkable map → 0. Enemy at (100,224) DOWN → e_map_collision[i]=1 (y=240 is out of bounds).
- Player (50,50), enemy0 (65,65) → c_e_collision[0]=1. Enemy0 at (66,50) → 0. Check done appears exactly 14 cycles after start with N=2, and busy is high in between.
- Pulse reset low at cycle 5 of a scan → no done, outputs 0. A following start completes normally.
- Hold start high: consecutive done pulses 15 cycles apart. Input changes mid-scan do not alter the results.
- With COLLISION_ENEMY_PAIR_EN: enemies at (30,30) and (40,40) → e_e_collision=2'b11. Move enemy1 to (46,30) → 2'b00.

Source files
------------

// File: rtl/collision_scanner.sv
// collision_scanner
//   Per-frame map and sprite collision scan for one player plus NUM_ENEMIES
//   enemies. All entities share one external level-map ROM port with a
//   1-cycle read latency. Each entity's probe box is its top-left position
//   shifted by MOVE_PX in the requested direction. The scan reads the four
//   corners of every probe box, one address per cycle. Player-enemy overlap
//   uses the latched, unshifted positions.
//
//   Optional build macro: COLLISION_ENEMY_PAIR_EN. When it is defined, the
//   block gains the e_e_collision output, which flags enemy-enemy overlaps.
//
// Ports
//   clock, reset            system clock, synchronous active-low reset
//   start                   scan request, sampled only while idle
//   char_x/char_y           player top-left position
//   direction_char          player move code
//   enemy_x/enemy_y         packed enemy positions (enemy i at [9i+8:9i] / [8i+7:8i])
//   direction_enemy         packed enemy move codes (3 bits each)
//   map_addr                level-map read address (y*SCREEN_W + x)
//   map_q                   map data for the previous cycle's address, 1 = walkable
//   busy                    scan in progress
//   done                    one-cycle pulse when the result outputs update
//   c_map_collision         player probe box hits a wall or a screen edge
//   e_map_collision         per-enemy probe box hits a wall or a screen edge
//   c_e_collision           player overlaps enemy i
//   e_e_collision           enemy i overlaps another enemy (macro builds only)
module collision_scanner #(
    parameter int NUM_ENEMIES = 2,
    parameter int SPRITE_SIZE = 16,
    parameter int MOVE_PX     = 1,
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [8:0]               char_x,
    input  logic [7:0]               char_y,
    input  logic [2:0]               direction_char,
    input  logic [9*NUM_ENEMIES-1:0] enemy_x,
    input  logic [8*NUM_ENEMIES-1:0] enemy_y,
    input  logic [3*NUM_ENEMIES-1:0] direction_enemy,
    output logic [16:0]              map_addr,
    input  logic                     map_q,
    output logic                     busy,
    output logic                     done,
    output logic                     c_map_collision,
    output logic [NUM_ENEMIES-1:0]   e_map_collision,
    output logic [NUM_ENEMIES-1:0]   c_e_collision
`ifdef COLLISION_ENEMY_PAIR_EN
    ,
    output logic [NUM_ENEMIES-1:0]   e_e_collision
`endif
);

    localparam int NE     = NUM_ENEMIES + 1;   // entities: player + enemies
    localparam int NPROBE = 4 * NE;
    localparam int IDX_W  = $clog2(NPROBE);
    localparam int ENT_W  = IDX_W - 2;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NPROBE - 1);
    localparam logic signed [10:0] MOVE_S   = 11'(MOVE_PX);
    localparam logic signed [10:0] SPAN_S   = 11'(SPRITE_SIZE - 1);
    localparam logic signed [10:0] W_S      = 11'(SCREEN_W);
    localparam logic signed [10:0] H_S      = 11'(SCREEN_H);
    localparam logic [16:0]        STRIDE   = 17'(SCREEN_W);
    localparam logic [8:0]         SIZE_U   = 9'(SPRITE_SIZE);

    typedef enum logic [2:0] {
        DIR_NONE   = 3'b000,
        DIR_ATTACK = 3'b001,
        DIR_UP     = 3'b010,
        DIR_DOWN   = 3'b011,
        DIR_LEFT   = 3'b100,
        DIR_RIGHT  = 3'b101
    } dir_e;

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_WAIT, S_DONE} state_e;

    state_e state_q, state_d;

    // Operands latched on start.
    logic [8:0] cx_q;
    logic [7:0] cy_q;
    logic [2:0] cdir_q;
    logic [8:0] ex_q   [NUM_ENEMIES];
    logic [7:0] ey_q   [NUM_ENEMIES];
    logic [2:0] edir_q [NUM_ENEMIES];

    logic [IDX_W-1:0] idx_q;       // probe index: entity*4 + corner
    logic [NE-1:0]    acc_q;       // per-entity map-hit accumulator
    logic             pv_q;        // previous cycle issued a probe
    logic [ENT_W-1:0] pent_q;      // entity of the previous probe
    logic             pblk_q;      // previous probe was out of bounds

    logic [ENT_W-1:0]       ent;
    logic [1:0]             corner;
    logic                   blk;
    logic [16:0]            addr;
    logic [NUM_ENEMIES-1:0] ce_ov;

    function automatic logic overlap(input logic [8:0] ax, input logic [7:0] ay,
                                     input logic [8:0] bx, input logic [7:0] by);
        logic [8:0] dx;
        logic [7:0] dy;
        dx = (ax >= bx) ? ax - bx : bx - ax;
        dy = (ay >= by) ? ay - by : by - ay;
        return (dx < SIZE_U) && ({1'b0, dy} < SIZE_U);
    endfunction

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PROBE;
            S_PROBE: if (idx_q == LAST_IDX) state_d = S_WAIT;
            S_WAIT:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- probe corner address / bounds ----------------
    always_comb begin
        logic [8:0]        sel_x;
        logic [7:0]        sel_y;
        logic [2:0]        sel_dir;
        logic signed [10:0] org_x, org_y, pt_x, pt_y;

        ent     = idx_q[IDX_W-1:2];
        corner  = idx_q[1:0];
        sel_x   = cx_q;
        sel_y   = cy_q;
        sel_dir = cdir_q;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (ent == ENT_W'(i + 1)) begin
                sel_x   = ex_q[i];
                sel_y   = ey_q[i];
                sel_dir = edir_q[i];
            end
        end

        org_x = $signed({2'b00, sel_x});
        org_y = $signed({3'b000, sel_y});
        case (sel_dir)
            DIR_UP:    org_y = org_y - MOVE_S;
            DIR_DOWN:  org_y = org_y + MOVE_S;
            DIR_LEFT:  org_x = org_x - MOVE_S;
            DIR_RIGHT: org_x = org_x + MOVE_S;
            default:   ;  // NO_ACTION, ATTACK and unused codes do not shift
        endcase

        // Corner order TL, TR, BL, BR: bit 0 selects right, bit 1 selects bottom.
        pt_x = org_x + (corner[0] ? SPAN_S : 11'sd0);
        pt_y = org_y + (corner[1] ? SPAN_S : 11'sd0);
        blk  = (pt_x < 11'sd0) || (pt_x >= W_S) || (pt_y < 11'sd0) || (pt_y >= H_S);
        addr = 17'(pt_y) * STRIDE + 17'(pt_x);
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy     = (state_q != S_IDLE);
        map_addr = '0;
        if (state_q == S_PROBE && !blk) map_addr = addr;
    end

    always_comb begin
        for (int i = 0; i < NUM_ENEMIES; i++)
            ce_ov[i] = overlap(cx_q, cy_q, ex_q[i], ey_q[i]);
    end

    // NOTE: latched operands carry no reset; they are always written on start
    // before anything reads them.
    always_ff @(posedge clock) begin
        if (state_q == S_IDLE && start) begin
            cx_q   <= char_x;
            cy_q   <= char_y;
            cdir_q <= direction_char;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                ex_q[i]   <= enemy_x[9*i +: 9];
                ey_q[i]   <= enemy_y[8*i +: 8];
                edir_q[i] <= direction_enemy[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            idx_q           <= '0;
            acc_q           <= '0;
            pv_q            <= 1'b0;
            pent_q          <= '0;
            pblk_q          <= 1'b0;
            done            <= 1'b0;
            c_map_collision <= 1'b0;
            e_map_collision <= '0;
            c_e_collision   <= '0;
        end else begin
            // map_q answers the address issued one cycle ago, so the probe's
            // entity and bounds verdict travel one stage alongside it.
            pv_q   <= (state_q == S_PROBE);
            pent_q <= ent;
            pblk_q <= blk;
            done   <= 1'b0;
            if (pv_q && (pblk_q || !map_q)) begin
                for (int i = 0; i < NE; i++)
                    if (pent_q == ENT_W'(i)) acc_q[i] <= 1'b1;
            end
            case (state_q)
                S_IDLE: if (start) begin
                    idx_q <= '0;
                    acc_q <= '0;
                end
                S_PROBE: idx_q <= idx_q + 1'b1;
                S_DONE: begin
                    done            <= 1'b1;
                    c_map_collision <= acc_q[0];
                    e_map_collision <= acc_q[NUM_ENEMIES:1];
                    c_e_collision   <= ce_ov;
                end
                default: ;
            endcase
        end
    end

`ifdef COLLISION_ENEMY_PAIR_EN
    // One unordered enemy pair (pi, pj) with pi < pj per probe cycle.
    // N(N-1)/2 pairs never exceed the 4(N+1) probe cycles.
    localparam logic [3:0] NE4 = 4'(NUM_ENEMIES);
    logic [3:0]             pi_q, pj_q;
    logic [NUM_ENEMIES-1:0] ee_acc_q;
    logic [8:0]             pa_x, pb_x;
    logic [7:0]             pa_y, pb_y;

    always_comb begin
        pa_x = '0;
        pa_y = '0;
        pb_x = '0;
        pb_y = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (pi_q == 4'(i)) begin pa_x = ex_q[i]; pa_y = ey_q[i]; end
            if (pj_q == 4'(i)) begin pb_x = ex_q[i]; pb_y = ey_q[i]; end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pi_q          <= '0;
            pj_q          <= '0;
            ee_acc_q      <= '0;
            e_e_collision <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    pi_q     <= 4'd0;
                    pj_q     <= 4'd1;
                    ee_acc_q <= '0;
                end
                S_PROBE: if (pj_q < NE4) begin
                    if (overlap(pa_x, pa_y, pb_x, pb_y)) begin
                        for (int i = 0; i < NUM_ENEMIES; i++)
                            if (pi_q == 4'(i) || pj_q == 4'(i)) ee_acc_q[i] <= 1'b1;
                    end
                    if (pj_q == NE4 - 4'd1) begin
                        pi_q <= pi_q + 4'd1;
                        pj_q <= pi_q + 4'd2;
                    end else begin
                        pj_q <= pj_q + 4'd1;
                    end
                end
                S_DONE: e_e_collision <= ee_acc_q;
                default: ;
            endcase
        end
    end
`else
    // Enemy-pair checker not built.
`endif

endmodule

// File: tb/tb_collision_scanner.sv
module tb_collision_scanner;

    localparam int N  = 2;
    localparam int S  = 16;
    localparam int MV = 1;
    localparam int W  = 320;
    localparam int H  = 240;
    localparam int LAT = 4 * (N + 1) + 2;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [8:0]     char_x = '0;
    logic [7:0]     char_y = '0;
    logic [2:0]     direction_char = '0;
    logic [9*N-1:0] enemy_x = '0;
    logic [8*N-1:0] enemy_y = '0;
    logic [3*N-1:0] direction_enemy = '0;
    logic [16:0]    map_addr;
    logic           map_q = 1'b1;
    logic           busy, done, c_map_collision;
    logic [N-1:0]   e_map_collision, c_e_collision;
`ifdef COLLISION_ENEMY_PAIR_EN
    logic [N-1:0]   e_e_collision;
`endif

    int checks = 0;
    int errors = 0;

    bit map_mem [0:W*H-1];
    int px, py, pd;
    int ex [N];
    int ey [N];
    int ed [N];

    collision_scanner #(.NUM_ENEMIES(N), .SPRITE_SIZE(S), .MOVE_PX(MV),
                        .SCREEN_W(W), .SCREEN_H(H)) dut (
        .clock(clock), .reset(reset), .start(start),
        .char_x(char_x), .char_y(char_y), .direction_char(direction_char),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .direction_enemy(direction_enemy),
        .map_addr(map_addr), .map_q(map_q), .busy(busy), .done(done),
        .c_map_collision(c_map_collision), .e_map_collision(e_map_collision),
        .c_e_collision(c_e_collision)
`ifdef COLLISION_ENEMY_PAIR_EN
        , .e_e_collision(e_e_collision)
`endif
    );

    always #5 clock = ~clock;

    // Level-map ROM, 1-cycle read latency.
    always @(posedge clock)
        map_q <= (int'(map_addr) < W * H) ? map_mem[int'(map_addr)] : 1'b1;

    // ---------------- reference model ----------------
    function automatic bit model_map(int x, int y, int dir);
        int ox, oy;
        bit hit;
        ox = x; oy = y; hit = 0;
        if (dir == 2) oy = oy - MV;
        if (dir == 3) oy = oy + MV;
        if (dir == 4) ox = ox - MV;
        if (dir == 5) ox = ox + MV;
        for (int c = 0; c < 4; c++) begin
            int cxp, cyp;
            cxp = ox + ((c % 2) ? S - 1 : 0);
            cyp = oy + ((c / 2) ? S - 1 : 0);
            if (cxp < 0 || cxp >= W || cyp < 0 || cyp >= H) hit = 1;
            else if (!map_mem[cyp * W + cxp]) hit = 1;
        end
        return hit;
    endfunction

    function automatic bit model_ov(int x0, int y0, int x1, int y1);
        int dx, dy;
        dx = (x0 > x1) ? x0 - x1 : x1 - x0;
        dy = (y0 > y1) ? y0 - y1 : y1 - y0;
        return (dx < S) && (dy < S);
    endfunction

    function automatic logic [N-1:0] exp_emap();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = model_map(ex[i], ey[i], ed[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_ce();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = model_ov(px, py, ex[i], ey[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_ee();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i != j && model_ov(ex[i], ey[i], ex[j], ey[j])) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_map(int mode);
        for (int i = 0; i < W * H; i++) begin
            case (mode)
                0:       map_mem[i] = 1'b1;
                1:       map_mem[i] = ((i % W) < 200);
                default: map_mem[i] = ($urandom_range(0, 15) != 0);
            endcase
        end
    endtask

    task automatic apply();
        char_x         = 9'(px);
        char_y         = 8'(py);
        direction_char = 3'(pd);
        for (int i = 0; i < N; i++) begin
            enemy_x[9*i +: 9]         = 9'(ex[i]);
            enemy_y[8*i +: 8]         = 8'(ey[i]);
            direction_enemy[3*i +: 3] = 3'(ed[i]);
        end
    endtask

    task automatic randomize_scene();
        px = $urandom_range(0, W - 1);
        py = $urandom_range(0, H - 1);
        pd = $urandom_range(0, 7);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                ex[i] = clampi(px + $urandom_range(0, 40) - 20, W - 1);
                ey[i] = clampi(py + $urandom_range(0, 40) - 20, H - 1);
            end else begin
                ex[i] = $urandom_range(0, W - 1);
                ey[i] = $urandom_range(0, H - 1);
            end
            ed[i] = $urandom_range(0, 7);
        end
    endtask

    // Starts one scan and returns the cycle offset of done (-1 on timeout).
    task automatic run_scan(output int lat, output bit busy_ok);
        @(negedge clock);
        apply();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (map_addr !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", map_addr); end
        checks++;
        if ({c_map_collision, e_map_collision, c_e_collision} !== '0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0", {c_map_collision, e_map_collision, c_e_collision});
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_wall_edge();
        int lat; bit bok;
        set_map(1);
        ex[0] = 10; ey[0] = 10; ed[0] = 0;
        ex[1] = 40; ey[1] = 150; ed[1] = 0;
        px = 183; py = 100; pd = 5;
        run_scan(lat, bok);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if (bok !== 1'b1) begin errors++; $display("FAIL busy_during_scan: got %b expected 1", bok); end
        checks++;
        if (c_map_collision !== 1'b0) begin errors++; $display("FAIL wall_199: got %b expected 0", c_map_collision); end
        px = 184;
        run_scan(lat, bok);
        checks++;
        if (c_map_collision !== 1'b1) begin errors++; $display("FAIL wall_200: got %b expected 1", c_map_collision); end
    endtask

    task automatic test_bounds();
        int lat; bit bok;
        set_map(0);
        px = 0; py = 50; pd = 4;
        ex[0] = 150; ey[0] = 150; ed[0] = 1;
        ex[1] = 100; ey[1] = 224; ed[1] = 3;
        run_scan(lat, bok);
        checks++;
        if (c_map_collision !== 1'b1) begin errors++; $display("FAIL left_edge: got %b expected 1", c_map_collision); end
        checks++;
        if (e_map_collision !== 2'b10) begin errors++; $display("FAIL bottom_edge: got %b expected 10", e_map_collision); end
        pd = 0;
        run_scan(lat, bok);
        checks++;
        if (c_map_collision !== 1'b0) begin errors++; $display("FAIL no_action_edge: got %b expected 0", c_map_collision); end
    endtask

    task automatic test_overlap();
        int lat; bit bok;
        set_map(0);
        px = 50; py = 50; pd = 0;
        ex[0] = 65; ey[0] = 65; ed[0] = 0;
        ex[1] = 250; ey[1] = 200; ed[1] = 0;
        run_scan(lat, bok);
        checks++;
        if (c_e_collision !== 2'b01) begin errors++; $display("FAIL overlap_15: got %b expected 01", c_e_collision); end
        ex[0] = 66; ey[0] = 50;
        run_scan(lat, bok);
        checks++;
        if (c_e_collision !== 2'b00) begin errors++; $display("FAIL overlap_16: got %b expected 00", c_e_collision); end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; bit seen;
        set_map(0);
        px = 0; py = 0; pd = 4;
        ex[0] = 5; ey[0] = 5; ed[0] = 0;
        ex[1] = 200; ey[1] = 100; ed[1] = 0;
        run_scan(lat, bok);
        checks++;
        if ({c_map_collision, c_e_collision} !== 3'b101) begin
            errors++;
            $display("FAIL pre_reset_result: got %b expected 101", {c_map_collision, c_e_collision});
        end
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_scan: got %b expected 1", busy); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if ({busy, done, map_addr, c_map_collision, e_map_collision, c_e_collision} !== '0) begin
            errors++;
            $display("FAIL mid_reset_state: got busy=%b done=%b addr=%0d flags=%b expected all 0",
                     busy, done, map_addr, {c_map_collision, e_map_collision, c_e_collision});
        end
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL aborted_done: got %b expected 0", seen); end
        run_scan(lat, bok);
        checks++;
        if (lat !== LAT || {c_map_collision, c_e_collision} !== 3'b101) begin
            errors++;
            $display("FAIL post_reset_scan: got lat=%0d flags=%b expected lat=%0d flags=101",
                     lat, {c_map_collision, c_e_collision}, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N:0] exp_a, exp_b, got_a, got_b;
        int d [2];
        int cnt;
        set_map(0);
        px = 60; py = 60; pd = 5;
        ex[0] = 70; ey[0] = 70; ed[0] = 0;
        ex[1] = 200; ey[1] = 150; ed[1] = 3;
        exp_a = {model_map(px, py, pd), exp_emap(), exp_ce()};
        exp_b = '0;
        got_a = '0;
        got_b = '0;
        d[0] = -1; d[1] = -1;
        cnt = 0;
        @(negedge clock);
        apply();
        start = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (n == 3) begin
                px = 0; py = 0; pd = 4;
                ex[0] = 300; ey[0] = 200; ed[0] = 5;
                ex[1] = 10; ey[1] = 230; ed[1] = 3;
                apply();
                exp_b = {model_map(px, py, pd), exp_emap(), exp_ce()};
            end
            if (done) begin
                d[cnt] = n;
                if (cnt == 0) got_a = {c_map_collision, e_map_collision, c_e_collision};
                else          got_b = {c_map_collision, e_map_collision, c_e_collision};
                cnt++;
                if (cnt == 2) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (d[0] !== LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", d[0], LAT); end
        checks++;
        if (d[1] - d[0] !== LAT + 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected %0d", d[1] - d[0], LAT + 1);
        end
        checks++;
        if (got_a !== exp_a) begin errors++; $display("FAIL b2b_first_result: got %b expected %b", got_a, exp_a); end
        checks++;
        if (got_b !== exp_b) begin errors++; $display("FAIL b2b_second_result: got %b expected %b", got_b, exp_b); end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_random();
        int lat; bit bok;
        set_map(2);
        for (int t = 0; t < 24; t++) begin
            randomize_scene();
            run_scan(lat, bok);
            checks++;
            if (lat !== LAT) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, lat, LAT); end
            checks++;
            if (c_map_collision !== model_map(px, py, pd)) begin
                errors++;
                $display("FAIL rnd%0d_cmap: got %b expected %b", t, c_map_collision, model_map(px, py, pd));
            end
            checks++;
            if (e_map_collision !== exp_emap()) begin
                errors++;
                $display("FAIL rnd%0d_emap: got %b expected %b", t, e_map_collision, exp_emap());
            end
            checks++;
            if (c_e_collision !== exp_ce()) begin
                errors++;
                $display("FAIL rnd%0d_ce: got %b expected %b", t, c_e_collision, exp_ce());
            end
`ifdef COLLISION_ENEMY_PAIR_EN
            checks++;
            if (e_e_collision !== exp_ee()) begin
                errors++;
                $display("FAIL rnd%0d_ee: got %b expected %b", t, e_e_collision, exp_ee());
            end
`endif
        end
    endtask

`ifdef COLLISION_ENEMY_PAIR_EN
    task automatic test_pair();
        int lat; bit bok;
        set_map(0);
        px = 250; py = 200; pd = 0;
        ex[0] = 30; ey[0] = 30; ed[0] = 0;
        ex[1] = 40; ey[1] = 40; ed[1] = 0;
        run_scan(lat, bok);
        checks++;
        if (e_e_collision !== 2'b11) begin errors++; $display("FAIL pair_overlap: got %b expected 11", e_e_collision); end
        ex[1] = 46; ey[1] = 30;
        run_scan(lat, bok);
        checks++;
        if (e_e_collision !== 2'b00) begin errors++; $display("FAIL pair_apart: got %b expected 00", e_e_collision); end
    endtask
`endif

    initial begin
        test_reset();
        test_wall_edge();
        test_bounds();
        test_overlap();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef COLLISION_ENEMY_PAIR_EN
        test_pair();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
